// File: rtl/uart_rx_core_if.sv
// Receive-side word interface of uart_rx_core: one received word plus its
// error flags, offered to the consumer under a valid/ready handshake.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: data_valid rises with a word and holds it (data_out and flags
  // stable) until a clock edge where data_valid && data_ready; that edge is
  // the transfer. data_ready may be driven high before data_valid.
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, 16x oversampled start detect, mid-bit
// sampling, parity/stop checks. Define UART_RX_MAJORITY_EN for 2-of-3 voting.
module uart_rx_core #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  output logic           rx_busy,
  output logic [2:0]     state_dbg,
  uart_rx_core_if.master rx_if
);
  localparam int   DIV     = CLK_FREQ / (BAUD_RATE * 16);
  localparam int   DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic PAR_ODD = (PARITY_MODE == 2);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_core: CLK_FREQ too low for 16x oversampling of BAUD_RATE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 os_tick;
  logic [3:0]           os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frame_err_q, done_q;
  logic                 samp_start, samp_bit, samp_val;
  logic                 accept;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Prescaler restarts at the falling edge so the bit grid is anchored to it.
  always_ff @(posedge clk) begin
    if (rst)                      div_cnt <= '0;
    else if (state == IDLE && !rx_s) div_cnt <= '0;
    else if (os_tick)             div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  assign os_tick = (div_cnt == DIV_W'(DIV - 1));

`ifdef UART_RX_MAJORITY_EN
  // Votes at 6/7/8 (start) or 14/15/0 (later bits); the decision lands one
  // tick late, so leaving START reloads os_cnt to 1 to keep the bit grid.
  localparam logic [3:0] OS_RESTART = 4'd1;
  logic [1:0] maj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      maj_q <= 2'b11;
    end else if (os_tick) begin
      if ((state == START) ? (os_cnt == 4'd6) : (os_cnt == 4'd14)) maj_q[0] <= rx_s;
      if ((state == START) ? (os_cnt == 4'd7) : (os_cnt == 4'd15)) maj_q[1] <= rx_s;
    end
  end

  assign samp_start = os_tick && (os_cnt == 4'd8);
  assign samp_bit   = os_tick && (os_cnt == 4'd0);
  assign samp_val   = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
  localparam logic [3:0] OS_RESTART = 4'd0;

  assign samp_start = os_tick && (os_cnt == 4'd7);
  assign samp_bit   = os_tick && (os_cnt == 4'd15);
  assign samp_val   = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_busy     <= 1'b0;
      os_cnt      <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (os_tick) os_cnt <= os_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
            os_cnt  <= '0;
          end
        end
        START: begin
          if (samp_start) begin
            if (samp_val) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state     <= DATA;
              os_cnt    <= OS_RESTART;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (samp_bit) begin
            shift_q <= {samp_val, shift_q[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(DATA_BITS - 1))
              state <= (PARITY_MODE == 0) ? STOP : PARITY;
          end
        end
        PARITY: begin
          if (samp_bit) begin
            par_err_q <= ((^shift_q) ^ samp_val) != PAR_ODD;
            state     <= STOP;
          end
        end
        STOP: begin
          // Back to IDLE right after mid-stop so a back-to-back start is caught.
          if (samp_bit) begin
            frame_err_q <= ~samp_val;
            done_q      <= 1'b1;
            state       <= IDLE;
            rx_busy     <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign accept = rx_if.data_valid && rx_if.data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_if.data_out    <= '0;
      rx_if.data_valid  <= 1'b0;
      rx_if.parity_err  <= 1'b0;
      rx_if.frame_err   <= 1'b0;
      rx_if.overrun_err <= 1'b0;
    end else if (done_q) begin
      if (!rx_if.data_valid || accept) begin
        rx_if.data_out   <= shift_q;
        rx_if.parity_err <= par_err_q;
        rx_if.frame_err  <= frame_err_q;
        rx_if.data_valid <= 1'b1;
        if (accept) rx_if.overrun_err <= 1'b0;
      end else begin
        // Held word wins; the new one is dropped and the loss is recorded.
        rx_if.overrun_err <= 1'b1;
      end
    end else if (accept) begin
      rx_if.data_valid  <= 1'b0;
      rx_if.overrun_err <= 1'b0;
    end
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Dedicated UART receiver for the serial link driven by our UART transmit path.
- Synchronises the asynchronous rx line and detects the start bit with 16x oversampling.
- Samples data LSB-first at mid-bit, checks parity and the stop bit.
- Presents each received word on a valid/ready handshake with per-word error flags.
- Sits between the pad-level rx pin and the consumer (FIFO or CSR block).

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  received word, LSB = first bit on the line.
- data_valid  output  1  data_out and the error flags hold a word not yet taken.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready.
- parity_err  output  1  parity mismatch on the presented word.
- frame_err  output  1  stop bit sampled low on the presented word.
- overrun_err  output  1  sticky: a frame completed while data_valid was high.
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, data_out = 0, FSM = IDLE, synchroniser flops = 1. Reset mid-frame abandons the frame and raises no flags.
- Synchroniser: 2-flop, reset value 1. The FSM sees rx_s only, which gives 2 clk of input latency.
- Prescaler: DIV = CLK_FREQ / (BAUD_RATE*16), integer division, elaboration error if DIV < 1. It produces a 1-clk os_tick every DIV clocks and reloads to 0 on the IDLE->START transition. A 4-bit os_cnt counts os_ticks within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s == 0, go to START and clear os_cnt.
  - START: on the os_tick where os_cnt == 7 (mid-bit), sample rx_s. If 1, treat as a false start: return to IDLE with no flags. If 0, clear os_cnt and go to DATA.
  - DATA: sample on each os_tick with os_cnt == 15, i.e. one bit period after the previous sample. Shift samples in LSB-first. After DATA_BITS samples, go to PARITY, or to STOP if PARITY_MODE == 0.
  - PARITY: sample once. Even mode: error if XOR(data, bit) != 0. Odd mode: error if XOR(data, bit) != 1.
  - STOP: sample once. frame_err_n = ~sample. Return to IDLE immediately after the mid-stop sample so the receiver resyncs to a back-to-back start bit.
- Output register:
  - Load: on the clock after the mid-stop sample, if data_valid == 0, load data_out, parity_err and frame_err and set data_valid = 1.
  - Hold: data_out and the flags stay stable while data_valid is high.
  - Handshake: data_valid clears on the clock where data_valid && data_ready.
  - Overrun: if a frame completes while data_valid == 1 (handshake not occurring in the same cycle), the new word is discarded, data_out is kept, and overrun_err is set.
  - Simultaneous completion and handshake: the new word is loaded, data_valid stays 1, and no overrun is flagged.
  - overrun_err clears on the next accepted handshake.
- Line break (stop bit low, all data 0): reported as a frame_err word only. No special state.
- rx_busy = (state != IDLE), registered.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each mid-bit sample, including the start check and the stop bit, is the 2-of-3 majority of rx_s at os_cnt 6, 7 and 8. In DATA, PARITY and STOP those positions map to os_cnt 14, 15 and 0 of the following tick window, so the decision is taken one os_tick later. Output latency therefore grows by exactly one os_tick.
- Undefined: single sample at os_cnt 7 for START and os_cnt 15 thereafter, with no extra storage.

Test Plan:
All scenarios use CLK_FREQ = 1_600_000, BAUD_RATE = 100_000 (DIV = 1, 16 clk/bit), DATA_BITS = 8, PARITY_MODE = 1.
- Frame 0xA5, parity 0, stop 1, data_ready = 1 -> data_out = 0xA5 and data_valid pulses 1 clk, 171 clk after the rx falling edge (2 sync + 168 + 1); all error flags 0.
- rx low for 4 clk, then high -> data_valid stays 0; rx_busy high, then 0 after the mid-start check; no flags.
- Frame 0x3C with parity bit 1 -> data_out = 0x3C, parity_err = 1, frame_err = 0.
- Frame 0x81, stop bit driven 0 -> frame_err = 1; a back-to-back frame 0x55 is received correctly once ready is given.
- Two frames 0x11 then 0x22 with data_ready = 0 -> data_out = 0x11, overrun_err = 1; raise data_ready for 1 clk -> data_valid = 0, overrun_err = 0.
- Assert rst for 1 clk mid-DATA of frame 0x77 -> all outputs 0, no word delivered; the next frame 0x99 is received with no flags.
